// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the SimpleRISC multi-cycle execute stage.
//   OP_*     : 4-bit opcode encodings presented on ex_unit_mc.op
//   state_e  : execute-stage FSM states
//   is_muldiv: true for opcodes handled by the iterative multiplier/divider
package ex_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_LSL = 4'd10;
    localparam logic [3:0] OP_LSR = 4'd11;
    localparam logic [3:0] OP_ASR = 4'd12;
    localparam logic [3:0] OP_NOP = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative shift-add multiplier / unsigned restoring divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin WIDTH iteration cycles (ignored while busy)
//   is_div     : 1 = divide (quotient + remainder), 0 = multiply (low WIDTH bits)
//   a, b       : multiplicand/dividend, multiplier/divisor
//   busy       : iteration in progress
//   done       : 1-cycle pulse during the last iteration cycle; the result
//                outputs are valid in that cycle and are captured by the caller
//                on the same edge that performs the last iteration
//   product, quotient, remainder : results (meaningful while done is high)
// Divide by zero needs no special case: every trial subtraction succeeds, so
// the quotient fills with ones and the remainder ends up equal to the dividend.
module iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    // Shared datapath registers:
    //   multiply: acc = partial product, opa = shifted multiplicand, opb = multiplier
    //   divide  : acc = partial remainder, opa = dividend/quotient, opb = divisor
    logic             busy_q,   busy_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] opa_q,    opa_d;
    logic [WIDTH-1:0] opb_q,    opb_d;

    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_opa;
    logic [WIDTH-1:0] step_opb;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    // One iteration step, from the current registers.
    always_comb begin
        rem_sh   = {acc_q, opa_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        if (is_div_q) begin
            if (!rem_diff[WIDTH]) begin
                step_acc = rem_diff[WIDTH-1:0];
                step_opa = {opa_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = rem_sh[WIDTH-1:0];
                step_opa = {opa_q[WIDTH-2:0], 1'b0};
            end
            step_opb = opb_q;
        end else begin
            step_acc = acc_q + (opb_q[0] ? opa_q : '0);
            step_opa = opa_q << 1;
            step_opb = opb_q >> 1;
        end
    end

    always_comb begin
        busy_d   = busy_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        if (busy_q) begin
            acc_d = step_acc;
            opa_d = step_opa;
            opb_d = step_opb;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            busy_d   = 1'b1;
            is_div_d = is_div;
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            opa_d    = a;
            opb_d    = b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(1));
    assign product   = step_acc;
    assign quotient  = step_opa;
    assign remainder = step_acc;

endmodule

// File: rtl/ex_unit_mc.sv
// ex_unit_mc: multi-cycle SimpleRISC execute stage (ALU, branch resolution, flags).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operation handshake (in_ready high only in IDLE)
//   op, is_imm           : opcode (ex_pkg::OP_*), B = is_imm ? immx : op2
//   is_ret, is_beq, is_ubranch, is_bgt : branch controls
//   op1, op2, immx, branch_target      : operands
//   out_valid / out_ready: result handshake (out_valid = state DONE)
//   alu_result, branch_pc, branch_taken, div_zero : registered results
//   flag_e, flag_gt      : persistent flags written only by CMP
// Single-cycle ops reach DONE on the accept edge; MUL/DIV/MOD go through the
// iterative unit and reach DONE WIDTH cycles later.
module ex_unit_mc
    import ex_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             is_imm,
    input  logic             is_ret,
    input  logic             is_beq,
    input  logic             is_ubranch,
    input  logic             is_bgt,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] immx,
    input  logic [WIDTH-1:0] branch_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] branch_pc,
    output logic             branch_taken,
    output logic             flag_e,
    output logic             flag_gt,
    output logic             div_zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_result_q,   alu_result_d;
    logic [WIDTH-1:0] branch_pc_q,    branch_pc_d;
    logic             branch_taken_q, branch_taken_d;
    logic             flag_e_q,       flag_e_d;
    logic             flag_gt_q,      flag_gt_d;
    logic             div_zero_q,     div_zero_d;
    logic             is_mod_q,       is_mod_d;

    logic [WIDTH-1:0] b_val;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_sc;
    logic             accept;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_product;
    logic [WIDTH-1:0] md_quotient;
    logic [WIDTH-1:0] md_remainder;

    assign b_val    = is_imm ? immx : op2;
    assign shamt    = b_val[SHW-1:0];
    assign accept   = in_valid && (state_q == ST_IDLE);
    assign md_start = accept && is_muldiv(op);

    iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_div    (op != OP_MUL),
        .a         (op1),
        .b         (b_val),
        .busy      (md_busy),
        .done      (md_done),
        .product   (md_product),
        .quotient  (md_quotient),
        .remainder (md_remainder)
    );

    // Single-cycle ALU; CMP, NOP and undefined opcodes yield 0.
    always_comb begin
        alu_sc = '0;
        unique case (op)
            OP_ADD:  alu_sc = op1 + b_val;
            OP_SUB:  alu_sc = op1 - b_val;
            OP_AND:  alu_sc = op1 & b_val;
            OP_OR:   alu_sc = op1 | b_val;
            OP_NOT:  alu_sc = ~b_val;
            OP_MOV:  alu_sc = b_val;
            OP_LSL:  alu_sc = op1 << shamt;
            OP_LSR:  alu_sc = op1 >> shamt;
            OP_ASR:  alu_sc = $unsigned($signed(op1) >>> shamt);
            default: alu_sc = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        alu_result_d   = alu_result_q;
        branch_pc_d    = branch_pc_q;
        branch_taken_d = branch_taken_q;
        flag_e_d       = flag_e_q;
        flag_gt_d      = flag_gt_q;
        div_zero_d     = div_zero_q;
        is_mod_d       = is_mod_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    branch_pc_d = is_ret ? op1 : branch_target;
                    // Reads the registered flags, so a CMP never branches on itself.
                    branch_taken_d = is_ubranch | (is_beq & flag_e_q) | (is_bgt & flag_gt_q);
                    div_zero_d = 1'b0;
                    if (op == OP_CMP) begin
                        flag_e_d  = (op1 == b_val);
                        flag_gt_d = ($signed(op1) > $signed(b_val));
                    end
                    if (op == OP_MUL) begin
                        state_d      = ST_MUL;
                        alu_result_d = '0;
                    end else if ((op == OP_DIV) || (op == OP_MOD)) begin
                        state_d      = ST_DIV;
                        alu_result_d = '0;
                        is_mod_d     = (op == OP_MOD);
                        div_zero_d   = (b_val == '0);
                    end else begin
                        state_d      = ST_DONE;
                        alu_result_d = alu_sc;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done) begin
                    if (state_q == ST_MUL) begin
                        alu_result_d = md_product;
                    end else begin
                        alu_result_d = is_mod_q ? md_remainder : md_quotient;
                    end
                    state_d = ST_DONE;
                end else if (!md_busy) begin
                    // Iterative unit idle without having signalled done: recover.
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            alu_result_q   <= '0;
            branch_pc_q    <= '0;
            branch_taken_q <= 1'b0;
            flag_e_q       <= 1'b0;
            flag_gt_q      <= 1'b0;
            div_zero_q     <= 1'b0;
            is_mod_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            alu_result_q   <= alu_result_d;
            branch_pc_q    <= branch_pc_d;
            branch_taken_q <= branch_taken_d;
            flag_e_q       <= flag_e_d;
            flag_gt_q      <= flag_gt_d;
            div_zero_q     <= div_zero_d;
            is_mod_q       <= is_mod_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign alu_result   = alu_result_q;
    assign branch_pc    = branch_pc_q;
    assign branch_taken = branch_taken_q;
    assign flag_e       = flag_e_q;
    assign flag_gt      = flag_gt_q;
    assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_ex_unit_mc.sv
// Testbench for ex_unit_mc: a WIDTH=32 and a WIDTH=8 instance share the clock,
// reset and operand buses; each has its own in_valid.
module tb_ex_unit_mc;
    import ex_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid32, in_valid8;
    logic        out_ready;
    logic [3:0]  op;
    logic        is_imm, is_ret, is_beq, is_ubranch, is_bgt;
    logic [31:0] op1, op2, immx, branch_target;

    logic        in_ready32, out_valid32, taken32, fe32, fgt32, dz32;
    logic [31:0] alu32, pc32;
    logic        in_ready8, out_valid8, taken8, fe8, fgt8, dz8;
    logic [7:0]  alu8, pc8;

    int n_checks = 0;
    int n_fail   = 0;

    ex_unit_mc #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op), .is_imm(is_imm), .is_ret(is_ret), .is_beq(is_beq),
        .is_ubranch(is_ubranch), .is_bgt(is_bgt), .op1(op1), .op2(op2),
        .immx(immx), .branch_target(branch_target), .out_valid(out_valid32),
        .out_ready(out_ready), .alu_result(alu32), .branch_pc(pc32),
        .branch_taken(taken32), .flag_e(fe32), .flag_gt(fgt32), .div_zero(dz32)
    );

    ex_unit_mc #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op), .is_imm(is_imm), .is_ret(is_ret), .is_beq(is_beq),
        .is_ubranch(is_ubranch), .is_bgt(is_bgt), .op1(op1[7:0]), .op2(op2[7:0]),
        .immx(immx[7:0]), .branch_target(branch_target[7:0]), .out_valid(out_valid8),
        .out_ready(out_ready), .alu_result(alu8), .branch_pc(pc8),
        .branch_taken(taken8), .flag_e(fe8), .flag_gt(fgt8), .div_zero(dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        bit          w8;
        logic [3:0]  op;
        logic        imm;
        logic [3:0]  br;   // {is_ret, is_beq, is_ubranch, is_bgt}
        logic [31:0] a, b, imx, tgt;
        logic [31:0] res;
        int          lat;
        logic        tk;
        logic [1:0]  fl;   // {flag_e, flag_gt}
        logic        dz;
    } vec_t;

    function automatic vec_t mk(string n, bit w8, logic [3:0] o, logic imm, logic [3:0] br,
                                logic [31:0] a, logic [31:0] b, logic [31:0] imx,
                                logic [31:0] tgt, logic [31:0] res, int lat, logic tk,
                                logic [1:0] fl, logic dz);
        vec_t v;
        v.name = n; v.w8 = w8; v.op = o; v.imm = imm; v.br = br;
        v.a = a; v.b = b; v.imx = imx; v.tgt = tgt; v.res = res;
        v.lat = lat; v.tk = tk; v.fl = fl; v.dz = dz;
        return v;
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void timeout(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endfunction

    function automatic logic rdy(bit w8);
        return w8 ? in_ready8 : in_ready32;
    endfunction

    function automatic logic ovalid(bit w8);
        return w8 ? out_valid8 : out_valid32;
    endfunction

    task automatic drive(input vec_t v);
        op            = v.op;
        is_imm        = v.imm;
        {is_ret, is_beq, is_ubranch, is_bgt} = v.br;
        op1           = v.a;
        op2           = v.b;
        immx          = v.imx;
        branch_target = v.tgt;
    endtask

    task automatic wait_ready(input bit w8, input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy(w8) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) timeout({name, "_ready"});
    endtask

    task automatic apply(input vec_t v);
        int          lat;
        logic [31:0] exp_pc;
        wait_ready(v.w8, v.name);
        drive(v);
        if (v.w8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8  = 1'b0;
        in_valid32 = 1'b0;
        lat = 1;
        while (!ovalid(v.w8) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) begin
            timeout({v.name, "_valid"});
        end else begin
            exp_pc = v.br[3] ? v.a : v.tgt;
            if (v.w8) exp_pc = exp_pc & 32'hFF;
            check({v.name, "_lat"}, lat, v.lat);
            if (v.w8) begin
                check({v.name, "_res"},   {24'h0, alu8}, v.res);
                check({v.name, "_pc"},    {24'h0, pc8}, exp_pc);
                check({v.name, "_taken"}, {31'h0, taken8}, {31'h0, v.tk});
                check({v.name, "_flags"}, {30'h0, fe8, fgt8}, {30'h0, v.fl});
                check({v.name, "_dz"},    {31'h0, dz8}, {31'h0, v.dz});
            end else begin
                check({v.name, "_res"},   alu32, v.res);
                check({v.name, "_pc"},    pc32, exp_pc);
                check({v.name, "_taken"}, {31'h0, taken32}, {31'h0, v.tk});
                check({v.name, "_flags"}, {30'h0, fe32, fgt32}, {30'h0, v.fl});
                check({v.name, "_dz"},    {31'h0, dz32}, {31'h0, v.dz});
            end
        end
    endtask

    vec_t tbl[$];
    vec_t vv;

    initial begin
        tbl.push_back(mk("add",      0, OP_ADD, 0, 4'b0000, 32'd7, 32'd5, 0, 0, 32'd12, 1, 0, 2'b00, 0));
        tbl.push_back(mk("sub_imm",  0, OP_SUB, 1, 4'b0000, 32'd3, 0, 32'd5, 0, 32'hFFFF_FFFE, 1, 0, 2'b00, 0));
        tbl.push_back(mk("mul",      0, OP_MUL, 0, 4'b0000, 32'hFFFF_FFFF, 32'd3, 0, 0, 32'hFFFF_FFFD, 33, 0, 2'b00, 0));
        tbl.push_back(mk("mul_imm",  0, OP_MUL, 1, 4'b0000, 32'h1234_5678, 0, 32'h10, 0, 32'h2345_6780, 33, 0, 2'b00, 0));
        tbl.push_back(mk("div",      0, OP_DIV, 0, 4'b0000, 32'd100, 32'd7, 0, 0, 32'd14, 33, 0, 2'b00, 0));
        tbl.push_back(mk("mod",      0, OP_MOD, 0, 4'b0000, 32'd100, 32'd7, 0, 0, 32'd2, 33, 0, 2'b00, 0));
        tbl.push_back(mk("div0",     0, OP_DIV, 0, 4'b0000, 32'd9, 32'd0, 0, 0, 32'hFFFF_FFFF, 33, 0, 2'b00, 1));
        tbl.push_back(mk("mod0",     0, OP_MOD, 0, 4'b0000, 32'd9, 32'd0, 0, 0, 32'd9, 33, 0, 2'b00, 1));
        tbl.push_back(mk("cmp_eq",   0, OP_CMP, 0, 4'b0000, 32'd5, 32'd5, 0, 0, 0, 1, 0, 2'b10, 0));
        tbl.push_back(mk("beq",      0, OP_NOP, 0, 4'b0100, 0, 0, 0, 32'h100, 0, 1, 1, 2'b10, 0));
        tbl.push_back(mk("cmp_neg",  0, OP_CMP, 0, 4'b0000, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 1, 0, 2'b00, 0));
        tbl.push_back(mk("bgt_nt",   0, OP_NOP, 0, 4'b0001, 0, 0, 0, 32'h200, 0, 1, 0, 2'b00, 0));
        tbl.push_back(mk("cmp_self", 0, OP_CMP, 1, 4'b0001, 32'd2, 0, 32'hFFFF_FFFF, 32'h300, 0, 1, 0, 2'b01, 0));
        tbl.push_back(mk("bgt_t",    0, OP_NOP, 0, 4'b0001, 0, 0, 0, 32'h400, 0, 1, 1, 2'b01, 0));
        tbl.push_back(mk("ret",      0, OP_NOP, 0, 4'b1010, 32'h40, 0, 0, 32'h999, 0, 1, 1, 2'b01, 0));
        tbl.push_back(mk("lsl",      0, OP_LSL, 1, 4'b0000, 32'd1, 0, 32'd33, 0, 32'd2, 1, 0, 2'b01, 0));
        tbl.push_back(mk("asr",      0, OP_ASR, 0, 4'b0000, 32'h8000_0000, 32'd4, 0, 0, 32'hF800_0000, 1, 0, 2'b01, 0));
        tbl.push_back(mk("lsr",      0, OP_LSR, 0, 4'b0000, 32'h8000_0000, 32'd4, 0, 0, 32'h0800_0000, 1, 0, 2'b01, 0));
        tbl.push_back(mk("and",      0, OP_AND, 0, 4'b0000, 32'hF0F0, 32'h0FF0, 0, 0, 32'h00F0, 1, 0, 2'b01, 0));
        tbl.push_back(mk("or",       0, OP_OR,  0, 4'b0000, 32'hF0F0, 32'h0FF0, 0, 0, 32'hFFF0, 1, 0, 2'b01, 0));
        tbl.push_back(mk("not",      0, OP_NOT, 1, 4'b0000, 32'h1234, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 2'b01, 0));
        tbl.push_back(mk("mov",      0, OP_MOV, 1, 4'b0000, 0, 0, 32'h1234, 0, 32'h1234, 1, 0, 2'b01, 0));
        tbl.push_back(mk("undef",    0, 4'hF,   0, 4'b0000, 32'd5, 32'd6, 0, 0, 0, 1, 0, 2'b01, 0));
        tbl.push_back(mk("add_wrap", 0, OP_ADD, 0, 4'b0000, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'd1, 1, 0, 2'b01, 0));
        tbl.push_back(mk("w8_add",   1, OP_ADD, 0, 4'b0000, 32'hF0, 32'h20, 0, 0, 32'h10, 1, 0, 2'b00, 0));
        tbl.push_back(mk("w8_mul",   1, OP_MUL, 0, 4'b0000, 32'hFF, 32'd3, 0, 0, 32'hFD, 9, 0, 2'b00, 0));
        tbl.push_back(mk("w8_div",   1, OP_DIV, 0, 4'b0000, 32'd100, 32'd7, 0, 0, 32'd14, 9, 0, 2'b00, 0));
        tbl.push_back(mk("w8_mod",   1, OP_MOD, 0, 4'b0000, 32'd100, 32'd7, 0, 0, 32'd2, 9, 0, 2'b00, 0));
        tbl.push_back(mk("w8_div0",  1, OP_DIV, 0, 4'b0000, 32'd9, 32'd0, 0, 0, 32'hFF, 9, 0, 2'b00, 1));
        tbl.push_back(mk("w8_mod0",  1, OP_MOD, 0, 4'b0000, 32'd9, 32'd0, 0, 0, 32'd9, 9, 0, 2'b00, 1));
        tbl.push_back(mk("w8_asr",   1, OP_ASR, 1, 4'b0000, 32'h80, 0, 32'd1, 0, 32'hC0, 1, 0, 2'b00, 0));
        tbl.push_back(mk("w8_cmp",   1, OP_CMP, 0, 4'b0000, 32'h01, 32'h80, 0, 0, 0, 1, 0, 2'b01, 0));
        tbl.push_back(mk("w8_cmp2",  1, OP_CMP, 0, 4'b0000, 32'h80, 32'h01, 0, 0, 0, 1, 0, 2'b00, 0));
        tbl.push_back(mk("w8_lsl",   1, OP_LSL, 1, 4'b0000, 32'h81, 0, 32'd9, 0, 32'h02, 1, 0, 2'b00, 0));

        // Reset
        rst_n = 1'b0; in_valid32 = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
        op = OP_NOP; is_imm = 0; is_ret = 0; is_beq = 0; is_ubranch = 0; is_bgt = 0;
        op1 = 0; op2 = 0; immx = 0; branch_target = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready32", {31'h0, in_ready32}, 32'd1);
        check("rst_valid32", {31'h0, out_valid32}, 32'd0);
        check("rst_alu32",   alu32, 32'd0);
        check("rst_pc32",    pc32, 32'd0);
        check("rst_misc32",  {28'h0, taken32, fe32, fgt32, dz32}, 32'd0);
        check("rst_ready8",  {31'h0, in_ready8}, 32'd1);
        check("rst_out8",    {15'h0, out_valid8, alu8, pc8}, 32'd0);

        foreach (tbl[i]) apply(tbl[i]);

        // Backpressure: outputs hold and in_ready stays low while DONE && !out_ready;
        // an op offered during DONE is only taken the cycle after release.
        wait_ready(0, "bp");
        vv = mk("bp_add", 0, OP_ADD, 0, 4'b0000, 32'd7, 32'd5, 0, 0, 0, 0, 0, 0, 0);
        drive(vv);
        out_ready  = 1'b0;
        in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        op1 = 32'd20; op2 = 32'd1; op = OP_SUB;
        check("bp_valid0", {31'h0, out_valid32}, 32'd1);
        check("bp_res0", alu32, 32'd12);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'h0, out_valid32}, 32'd1);
            check("bp_hold_res", alu32, 32'd12);
            check("bp_hold_ready", {31'h0, in_ready32}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'h0, out_valid32}, 32'd0);
        check("bp_release_ready", {31'h0, in_ready32}, 32'd1);
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        check("bp_next_valid", {31'h0, out_valid32}, 32'd1);
        check("bp_next_res", alu32, 32'd19);

        // Reset during the 10th MUL iteration.
        wait_ready(0, "rst_mul");
        vv = mk("rst_mul", 0, OP_MUL, 0, 4'b0010, 32'h1234_5678, 32'h10, 0, 32'h77, 0, 0, 0, 0, 0);
        drive(vv);
        in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        check("mid_pc_before", pc32, 32'h77);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, out_valid32}, 32'd0);
        check("mid_rst_ready", {31'h0, in_ready32}, 32'd1);
        check("mid_rst_alu", alu32, 32'd0);
        check("mid_rst_pc", pc32, 32'd0);
        check("mid_rst_misc", {28'h0, taken32, fe32, fgt32, dz32}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_idle_valid", {31'h0, out_valid32}, 32'd0);
        apply(mk("post_rst_add", 0, OP_ADD, 0, 4'b0000, 32'd7, 32'd5, 0, 0, 32'd12, 1, 0, 2'b00, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
